axilite_m_arb: RTL
==================

AXILITE_M_ARB -- requirements
Module: axilite_m_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of every command.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of every command.
REQ-003 SHALL have port m_axi_aclk  in  1  the only clock; all logic is rising-edge.
REQ-004 SHALL have port m_axi_aresetn  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports reqN_valid  in  1  requester N command pending, for N = 0 and 1.
REQ-006 SHALL have ports reqN_wr  in  1  requester N direction: 1 = write, 0 = read.
REQ-007 SHALL have ports reqN_addr  in  ADDR_W  requester N address.
REQ-008 SHALL have ports reqN_wdata  in  DATA_W  requester N write data.
REQ-009 SHALL have ports reqN_done  out  1  one-cycle completion pulse to requester N.
REQ-010 SHALL have ports reqN_rdata  out  DATA_W  read data, qualified by reqN_done.
REQ-011 SHALL have ports reqN_resp  out  2  AXI response, qualified by reqN_done.
REQ-012 SHALL have ports reqN_timeout  out  1  timeout flag, qualified by reqN_done.
REQ-013 SHALL have ports mst_new_tx  out  1, mst_wr  out  1, mst_waddr  out  ADDR_W, mst_raddr  out  ADDR_W and mst_din  out  DATA_W, together forming the command to axilite_m.
REQ-014 SHALL have ports mst_dout  in  DATA_W, mst_wr_timeout  in  1 and mst_rd_timeout  in  1, carrying status from axilite_m.
REQ-015 SHALL have ports m_axi_bvalid, m_axi_bready, m_axi_rvalid and m_axi_rready  in  1 each, as monitor-only taps of the AXI bus.
REQ-016 SHALL have ports m_axi_bresp  in  2 and m_axi_rresp  in  2, as monitor-only taps of the AXI response channels.

Function
REQ-017 SHALL implement states IDLE, BUSY and RESP.
REQ-018 SHALL, in IDLE, move to BUSY on the next edge when any reqN_valid=1, registering the winner's wr, addr and wdata.
REQ-019 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; with one valid, grant that one.
REQ-020 SHALL hold mst_new_tx=1 and stable command fields for every BUSY cycle, giving 1-cycle latency from reqN_valid to mst_new_tx.
REQ-021 SHALL drive mst_waddr with the granted address on a write and mst_raddr with the granted address on a read, the unused address port being 0.
REQ-022 SHALL end a write in BUSY on m_axi_bvalid&m_axi_bready (resp=m_axi_bresp, rdata=0) or on mst_wr_timeout (resp=2'b10, timeout=1).
REQ-023 SHALL end a read in BUSY on m_axi_rvalid&m_axi_rready (rdata=mst_dout, resp=m_axi_rresp) or on mst_rd_timeout (rdata=0, resp=2'b10, timeout=1).
REQ-024 SHALL give the handshake priority over the timeout when both occur in the same cycle.
REQ-025 SHALL, on completion, register the results and go to RESP, where mst_new_tx=0 and the granted reqN_done=1 for exactly one cycle, then return to IDLE.
REQ-026 SHALL hold reqN_rdata, reqN_resp and reqN_timeout until that requester's next reqN_done.
REQ-027 SHALL ignore reqN_valid deassertion during BUSY: the transaction completes and reqN_done still pulses.
REQ-028 SHALL arbitrate again in the IDLE cycle after RESP, so one requester holding reqN_valid cannot starve the other.
REQ-029 SHALL ignore timeouts and handshakes seen in IDLE or RESP.

Reset
REQ-030 SHALL, while m_axi_aresetn=0 at a clock edge, enter IDLE, clear all outputs and registered results to 0, and set the last-grant pointer to 1 so requester 0 wins first.
REQ-031 SHALL abandon any in-flight transaction on reset mid-BUSY, issuing no reqN_done.

Structure
REQ-032 SHALL take the state enum and the constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 from package axilite_arb_pkg.
REQ-033 SHALL place the grant logic and last-grant pointer in the sub-module rr_arb2.

Verification
REQ-034 SHALL cover: req0 writes addr 0x4, data 0xA5 -> mst_new_tx one cycle later, mst_waddr=0x4, mst_din=0xA5; bvalid&bready with bresp 00 -> req0_done pulse, resp 00.
REQ-035 SHALL cover: req1 reads addr 0x8; rvalid&rready with mst_dout=5 -> req1_done, rdata=5, resp 00.
REQ-036 SHALL cover: req0 and req1 valid at the same time and held -> grants alternate 0,1,0,1 over four transactions.
REQ-037 SHALL cover: write with no bvalid and mst_wr_timeout=1 -> req0_done, resp 2'b10, timeout=1, mst_new_tx=0 the next cycle.
REQ-038 SHALL cover: rvalid&rready and mst_rd_timeout in the same cycle -> rresp reported, timeout=0.
REQ-039 SHALL cover: reset pulled low mid-BUSY -> all outputs 0, no done pulse; after release req0 is granted first.

Source files
------------

// File: rtl/axilite_arb_pkg.sv
// Shared types and constants for the two-requester AXI-Lite command arbiter.
// The state enum is also exported on the top's debug port.
package axilite_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer.
// The pointer only moves when the caller commits the grant (i_take).
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_grant
);

    logic r_last;

    // Contention goes to whoever was not served last; otherwise the lone requester wins.
    always_comb begin
        if (i_req == 2'b11) begin
            o_grant = ~r_last;
        end else begin
            o_grant = i_req[1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_take) begin
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/axilite_m_arb.sv
// Arbitrates two command requesters onto a single axilite_m command port and
// routes completion status (data, response, timeout) back to the winner.
module axilite_m_arb
    import axilite_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,

    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic [1:0]        req0_resp,
    output logic              req0_timeout,

    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [1:0]        req1_resp,
    output logic              req1_timeout,

    output logic              mst_new_tx,
    output logic              mst_wr,
    output logic [ADDR_W-1:0] mst_waddr,
    output logic [ADDR_W-1:0] mst_raddr,
    output logic [DATA_W-1:0] mst_din,
    input  logic [DATA_W-1:0] mst_dout,
    input  logic              mst_wr_timeout,
    input  logic              mst_rd_timeout,

    input  logic              m_axi_bvalid,
    input  logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_rvalid,
    input  logic              m_axi_rready,
    input  logic [1:0]        m_axi_rresp,

    output arb_state_e        o_dbg_state
);

    // Handshake: reqN_valid is a level request sampled only in IDLE; once taken the
    // command runs to completion regardless of reqN_valid and ends with one reqN_done pulse.

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;

    logic              r_sel;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [1:0]        r_resp0;
    logic [1:0]        r_resp1;
    logic              r_to0;
    logic              r_to1;

    logic              w_grant;
    logic              w_take;
    logic              w_cmpl;
    logic [DATA_W-1:0] w_rdata;
    logic [1:0]        w_resp;
    logic              w_to;
    logic              w_busy;
    logic              w_in_resp;

    assign w_take = (r_state == ST_IDLE) && (req0_valid || req1_valid);

    rr_arb2 u_rr_arb2 (
        .i_clk   (m_axi_aclk),
        .i_rst_n (m_axi_aresetn),
        .i_req   ({req1_valid, req0_valid}),
        .i_take  (w_take),
        .o_grant (w_grant)
    );

    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake is checked before timeout so a late-but-valid response wins.
    always_comb begin
        w_state_nxt = r_state;
        w_cmpl      = 1'b0;
        w_rdata     = '0;
        w_resp      = RESP_OKAY;
        w_to        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_wr) begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        w_cmpl = 1'b1;
                        w_resp = m_axi_bresp;
                    end else if (mst_wr_timeout) begin
                        w_cmpl = 1'b1;
                        w_resp = RESP_SLVERR;
                        w_to   = 1'b1;
                    end
                end else begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        w_cmpl  = 1'b1;
                        w_rdata = mst_dout;
                        w_resp  = m_axi_rresp;
                    end else if (mst_rd_timeout) begin
                        w_cmpl = 1'b1;
                        w_resp = RESP_SLVERR;
                        w_to   = 1'b1;
                    end
                end
                if (w_cmpl) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            r_sel    <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_resp0  <= RESP_OKAY;
            r_resp1  <= RESP_OKAY;
            r_to0    <= 1'b0;
            r_to1    <= 1'b0;
        end else begin
            if (w_take) begin
                r_sel   <= w_grant;
                r_wr    <= w_grant ? req1_wr    : req0_wr;
                r_addr  <= w_grant ? req1_addr  : req0_addr;
                r_wdata <= w_grant ? req1_wdata : req0_wdata;
            end
            if (w_cmpl) begin
                if (r_sel) begin
                    r_rdata1 <= w_rdata;
                    r_resp1  <= w_resp;
                    r_to1    <= w_to;
                end else begin
                    r_rdata0 <= w_rdata;
                    r_resp0  <= w_resp;
                    r_to0    <= w_to;
                end
            end
        end
    end

    assign w_busy    = (r_state == ST_BUSY);
    assign w_in_resp = (r_state == ST_RESP);

    assign mst_new_tx = w_busy;
    assign mst_wr     = w_busy && r_wr;
    assign mst_waddr  = (w_busy && r_wr)  ? r_addr : '0;
    assign mst_raddr  = (w_busy && !r_wr) ? r_addr : '0;
    assign mst_din    = w_busy ? r_wdata : '0;

    assign req0_done    = w_in_resp && !r_sel;
    assign req1_done    = w_in_resp && r_sel;
    assign req0_rdata   = r_rdata0;
    assign req0_resp    = r_resp0;
    assign req0_timeout = r_to0;
    assign req1_rdata   = r_rdata1;
    assign req1_resp    = r_resp1;
    assign req1_timeout = r_to1;

    assign o_dbg_state = r_state;

endmodule
